falafel_mem_port: RTL and testbench
===================================

Name: falafel_mem_port

Overview:
- Memory-side endpoint consumed directly downstream of the falafel load/store unit.
- Accepts its single-word load, store and compare-and-swap requests and executes them against an internal word-addressed backing store with configurable latency.
- Returns one response word per request; lock word at word 0 supports the LOCK/UNLOCK protocol.
- Serves as the memory model for allocator bring-up and as the template for the later real memory adapter.

Parameters:
- DATA_W, 64, request/response data and address width (from falafel_pkg).
- DEPTH_WORDS, 256, number of DATA_W-bit words in the backing store; power of two.
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.
- CAS_EXP_VAL, EMPTY_KEY, expected (free) value compared by CAS; also the reset value of word 0.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- mem_req_val_i  in  1  request valid.
- mem_req_rdy_o  out  1  request ready.
- mem_req_is_write_i  in  1  1 = store, 0 = load (ignored when is_cas = 1).
- mem_req_is_cas_i  in  1  1 = compare-and-swap.
- mem_req_addr_i  in  DATA_W  byte address.
- mem_req_data_i  in  DATA_W  store data / CAS swap value.
- mem_rsp_val_o  out  1  response valid.
- mem_rsp_rdy_i  in  1  consumer ready.
- mem_rsp_data_o  out  DATA_W  response data.
- cas_fail_cnt_o  out  16  saturating count of failed CAS operations.

Behaviour:
- Reset (asynchronous, active-low):
  - FSM to IDLE.
  - mem_rsp_val_o = 0, mem_rsp_data_o = 0, cas_fail_cnt_o = 0.
  - mem_req_rdy_o = 1 once in IDLE.
  - Word 0 = CAS_EXP_VAL; all other words = 0.
- Word index: addr[$clog2(DEPTH_WORDS)+2:3] (8-byte words). Higher address bits are ignored, so out-of-range addresses wrap. addr[2:0] is ignored.
- Operation select: is_cas has priority over is_write.
- FSM states IDLE, BUSY, RSP. One transaction outstanding at a time.
  - IDLE:
    - mem_req_rdy_o = 1.
    - On val & rdy at edge T: latch op, index and data; cnt <= LATENCY-1; go to BUSY.
  - BUSY:
    - mem_req_rdy_o = 0.
    - If cnt != 0: decrement cnt.
    - If cnt == 0, execute the op at that edge:
      - Load: rsp_data <= mem[idx].
      - Store: mem[idx] <= data; rsp_data <= 0.
      - CAS, mem[idx] == CAS_EXP_VAL: mem[idx] <= data; rsp_data <= 0 (success).
      - CAS, mem[idx] != CAS_EXP_VAL: memory unchanged; rsp_data <= 1; cas_fail_cnt_o increments, saturating at 16'hFFFF.
      - Then set mem_rsp_val_o and go to RSP.
    - Net effect: mem_rsp_val_o first high in cycle T+LATENCY.
  - RSP:
    - mem_rsp_val_o and mem_rsp_data_o held stable until mem_rsp_rdy_i.
    - On handshake: val drops next cycle, FSM to IDLE.
    - mem_req_rdy_o stays 0 in RSP; there is no same-cycle bypass. Minimum request-to-request spacing is LATENCY+2 cycles.
- Requests with mem_req_val_i high while rdy is low are not sampled. The requester must hold them stable until accepted.
- mem_rsp_rdy_i high before the response exists has no effect.
- A store to word 0 writing CAS_EXP_VAL releases the lock; the next CAS to word 0 then succeeds.
- Reset asserted mid-BUSY: the transaction is dropped, no memory commit, no response.
- Reset asserted mid-RSP: the response is discarded.

Test Plan:
- Store 0x1234 to addr 0x18, then load addr 0x18 -> rsp_data 0 for the store, then 0x1234. Each response is first valid exactly LATENCY cycles after acceptance (LATENCY = 2 and LATENCY = 1 runs).
- After reset, CAS addr 0 with data 0x5 -> rsp 0 and word 0 = 0x5. A second CAS -> rsp 1 with cas_fail_cnt_o = 1. Store CAS_EXP_VAL to addr 0, then CAS -> rsp 0.
- Hold mem_rsp_rdy_i low for 5 cycles in RSP -> val and data stable, mem_req_rdy_o stays 0. A pending request is accepted only in the first IDLE cycle after the handshake.
- Address wrap: store 0xAA to addr DEPTH_WORDS*8 + 0x8 -> a load of addr 0x8 returns 0xAA.
- Assert rst_ni low one cycle after accepting a store of 0x77 to addr 0x10 -> no response; after reset, a load of 0x10 returns 0.
- Force 65540 failing CAS operations -> cas_fail_cnt_o saturates at 0xFFFF.

Source files
------------

// File: rtl/falafel_mem_port.sv
// -----------------------------------------------------------------------------
// falafel_mem_port
//
// Memory-side endpoint for the falafel load/store unit. It executes
// single-word load, store and compare-and-swap (CAS) requests against an
// internal word-addressed backing store and returns one response word per
// request. Only one transaction is in flight at a time.
//
// Word 0 is the lock word. It resets to CAS_EXP_VAL, which means "free".
// - A CAS that finds CAS_EXP_VAL swaps in the new value and returns 0.
// - A CAS that finds any other value leaves memory unchanged and returns 1.
// - Storing CAS_EXP_VAL back to word 0 releases the lock.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   mem_req_val_i/rdy_o    request handshake
//   mem_req_is_write_i     1 = store, 0 = load (ignored when is_cas = 1)
//   mem_req_is_cas_i       1 = compare-and-swap
//   mem_req_addr_i         byte address (8-byte words, high bits wrap)
//   mem_req_data_i         store data / CAS swap value
//   mem_rsp_val_o/rdy_i    response handshake
//   mem_rsp_data_o         load data; 0 = store/CAS ok, 1 = CAS failed
//   cas_fail_cnt_o         saturating count of failed CAS operations
// -----------------------------------------------------------------------------
module falafel_mem_port #(
    parameter int                DATA_W      = 64,
    parameter int                DEPTH_WORDS = 256,
    parameter int                LATENCY     = 2,
    parameter logic [DATA_W-1:0] CAS_EXP_VAL = {DATA_W{1'b1}}
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mem_req_val_i,
    output logic              mem_req_rdy_o,
    input  logic              mem_req_is_write_i,
    input  logic              mem_req_is_cas_i,
    input  logic [DATA_W-1:0] mem_req_addr_i,
    input  logic [DATA_W-1:0] mem_req_data_i,
    output logic              mem_rsp_val_o,
    input  logic              mem_rsp_rdy_i,
    output logic [DATA_W-1:0] mem_rsp_data_o,
    output logic [15:0]       cas_fail_cnt_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_STORE = 2'd1;
    localparam logic [1:0] OP_CAS   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              req_rdy_q, req_rdy_d;
    logic              rsp_val_q, rsp_val_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [15:0]       cas_fail_cnt_q, cas_fail_cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    logic              mem_we_s;
    logic [DATA_W-1:0] rd_data_s;
    logic              unused_addr_s;

    // Only the word-index bits of the address matter; the rest wrap or are byte offset.
    assign unused_addr_s = ^{mem_req_addr_i[DATA_W-1:IDX_W+3], mem_req_addr_i[2:0]};

    assign rd_data_s      = mem_q[idx_q];
    assign mem_req_rdy_o  = req_rdy_q;
    assign mem_rsp_val_o  = rsp_val_q;
    assign mem_rsp_data_o = rsp_data_q;
    assign cas_fail_cnt_o = cas_fail_cnt_q;

    // Next-state logic for the IDLE/BUSY/RSP transaction FSM and its datapath.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        idx_d          = idx_q;
        wdata_d        = wdata_q;
        rsp_val_d      = rsp_val_q;
        rsp_data_d     = rsp_data_q;
        cas_fail_cnt_d = cas_fail_cnt_q;
        mem_we_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_req_val_i) begin
                    // CAS takes priority over the write flag.
                    if (mem_req_is_cas_i) begin
                        op_d = OP_CAS;
                    end else if (mem_req_is_write_i) begin
                        op_d = OP_STORE;
                    end else begin
                        op_d = OP_LOAD;
                    end
                    idx_d   = mem_req_addr_i[IDX_W+2:3];
                    wdata_d = mem_req_data_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // The operation commits on the edge that raises the response.
                    case (op_q)
                        OP_LOAD: begin
                            rsp_data_d = rd_data_s;
                        end
                        OP_STORE: begin
                            mem_we_s   = 1'b1;
                            rsp_data_d = {DATA_W{1'b0}};
                        end
                        OP_CAS: begin
                            if (rd_data_s == CAS_EXP_VAL) begin
                                mem_we_s   = 1'b1;
                                rsp_data_d = {DATA_W{1'b0}};
                            end else begin
                                rsp_data_d = DATA_W'(1);
                                if (cas_fail_cnt_q != 16'hFFFF) begin
                                    cas_fail_cnt_d = cas_fail_cnt_q + 16'd1;
                                end else begin
                                    cas_fail_cnt_d = cas_fail_cnt_q;
                                end
                            end
                        end
                        default: begin
                            rsp_data_d = {DATA_W{1'b0}};
                        end
                    endcase
                    rsp_val_d = 1'b1;
                    state_d   = ST_RSP;
                end
            end
            ST_RSP: begin
                if (mem_rsp_rdy_i) begin
                    rsp_val_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    rsp_val_d = 1'b1;
                end
            end
            default: begin
                rsp_val_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
        // Ready is registered, so it is derived from the state being entered.
        req_rdy_d = (state_d == ST_IDLE);
    end

    // FSM, control and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            cnt_q          <= {CNT_W{1'b0}};
            op_q           <= OP_LOAD;
            idx_q          <= {IDX_W{1'b0}};
            wdata_q        <= {DATA_W{1'b0}};
            req_rdy_q      <= 1'b1;
            rsp_val_q      <= 1'b0;
            rsp_data_q     <= {DATA_W{1'b0}};
            cas_fail_cnt_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            idx_q          <= idx_d;
            wdata_q        <= wdata_d;
            req_rdy_q      <= req_rdy_d;
            rsp_val_q      <= rsp_val_d;
            rsp_data_q     <= rsp_data_d;
            cas_fail_cnt_q <= cas_fail_cnt_d;
        end
    end

    // Backing store. Reset frees the lock word and clears everything else.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            mem_q[0] <= CAS_EXP_VAL;
        end else if (mem_we_s) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_falafel_mem_port.sv
// -----------------------------------------------------------------------------
// tb_falafel_mem_port
//
// Directed self-checking bench for falafel_mem_port. It drives two instances
// that share one clock and one reset:
//   port 0: LATENCY = 2
//   port 1: LATENCY = 1
// Every task starts and ends on a falling clock edge. Inputs change there and
// outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_falafel_mem_port;

    localparam logic [63:0] EXP_VAL = {64{1'b1}};

    logic        clk;
    logic        rst_n;
    logic        req_val [2];
    logic        req_rdy [2];
    logic        req_w   [2];
    logic        req_c   [2];
    logic [63:0] req_addr[2];
    logic [63:0] req_data[2];
    logic        rsp_val [2];
    logic        rsp_rdy [2];
    logic [63:0] rsp_data[2];
    logic [15:0] fail_cnt[2];

    int n_checks = 0;
    int n_fail   = 0;

    falafel_mem_port #(.DATA_W(64), .DEPTH_WORDS(256), .LATENCY(2)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_req_val_i(req_val[0]), .mem_req_rdy_o(req_rdy[0]),
        .mem_req_is_write_i(req_w[0]), .mem_req_is_cas_i(req_c[0]),
        .mem_req_addr_i(req_addr[0]), .mem_req_data_i(req_data[0]),
        .mem_rsp_val_o(rsp_val[0]), .mem_rsp_rdy_i(rsp_rdy[0]),
        .mem_rsp_data_o(rsp_data[0]), .cas_fail_cnt_o(fail_cnt[0])
    );

    falafel_mem_port #(.DATA_W(64), .DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_req_val_i(req_val[1]), .mem_req_rdy_o(req_rdy[1]),
        .mem_req_is_write_i(req_w[1]), .mem_req_is_cas_i(req_c[1]),
        .mem_req_addr_i(req_addr[1]), .mem_req_data_i(req_data[1]),
        .mem_rsp_val_o(rsp_val[1]), .mem_rsp_rdy_i(rsp_rdy[1]),
        .mem_rsp_data_o(rsp_data[1]), .cas_fail_cnt_o(fail_cnt[1])
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request and return on the falling edge after it is accepted.
    task automatic send(input int p, input logic w, input logic c,
                        input logic [63:0] addr, input logic [63:0] data);
        int k;
        req_val[p]  = 1'b1;
        req_w[p]    = w;
        req_c[p]    = c;
        req_addr[p] = addr;
        req_data[p] = data;
        k = 0;
        while (!req_rdy[p] && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("req_accept", {63'd0, req_rdy[p]}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_val[p] = 1'b0;
    endtask

    // Count cycles from acceptance until the response is valid (bounded).
    task automatic await_rsp(input int p, output logic [63:0] rsp, output int lat);
        lat = 0;
        while (!rsp_val[p] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rsp = rsp_data[p];
    endtask

    task automatic ack(input int p);
        rsp_rdy[p] = 1'b1;
        @(negedge clk);
        rsp_rdy[p] = 1'b0;
    endtask

    task automatic xact(input int p, input string tag, input logic w, input logic c,
                        input logic [63:0] addr, input logic [63:0] data,
                        input logic [63:0] exp_rsp);
        logic [63:0] rsp;
        int          lat;
        send(p, w, c, addr, data);
        await_rsp(p, rsp, lat);
        chk({tag, "_lat"}, 64'(lat), (p == 0) ? 64'd2 : 64'd1);
        chk({tag, "_rsp"}, rsp, exp_rsp);
        ack(p);
    endtask

    initial begin
        logic [63:0] rsp;
        int          lat;
        for (int p = 0; p < 2; p++) begin
            req_val[p]  = 1'b0;
            req_w[p]    = 1'b0;
            req_c[p]    = 1'b0;
            req_addr[p] = 64'd0;
            req_data[p] = 64'd0;
            rsp_rdy[p]  = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state.
        chk("rst_rsp_val", {63'd0, rsp_val[0]}, 64'd0);
        chk("rst_rsp_data", rsp_data[0], 64'd0);
        chk("rst_fail_cnt", {48'd0, fail_cnt[0]}, 64'd0);
        chk("rst_req_rdy", {63'd0, req_rdy[0]}, 64'd1);

        // Store then load, at both latencies.
        xact(0, "st18_l2", 1'b1, 1'b0, 64'h18, 64'h1234, 64'd0);
        xact(0, "ld18_l2", 1'b0, 1'b0, 64'h18, 64'd0, 64'h1234);
        xact(1, "st18_l1", 1'b1, 1'b0, 64'h18, 64'h1234, 64'd0);
        xact(1, "ld18_l1", 1'b0, 1'b0, 64'h18, 64'd0, 64'h1234);

        // Lock protocol on word 0.
        xact(0, "cas_ok", 1'b0, 1'b1, 64'h0, 64'h5, 64'd0);
        xact(0, "ld0_locked", 1'b0, 1'b0, 64'h0, 64'd0, 64'h5);
        xact(0, "cas_fail", 1'b1, 1'b1, 64'h0, 64'h6, 64'd1);
        chk("fail_cnt_1", {48'd0, fail_cnt[0]}, 64'd1);
        xact(0, "ld0_unchanged", 1'b0, 1'b0, 64'h0, 64'd0, 64'h5);
        xact(0, "st0_release", 1'b1, 1'b0, 64'h0, EXP_VAL, 64'd0);
        xact(0, "cas_relock", 1'b0, 1'b1, 64'h0, 64'h7, 64'd0);
        xact(0, "ld0_relocked", 1'b0, 1'b0, 64'h0, 64'd0, 64'h7);

        // Response held for 5 cycles while another request waits.
        send(0, 1'b0, 1'b0, 64'h18, 64'd0);
        await_rsp(0, rsp, lat);
        chk("hold_lat", 64'(lat), 64'd2);
        req_val[0]  = 1'b1;
        req_w[0]    = 1'b1;
        req_c[0]    = 1'b0;
        req_addr[0] = 64'h18;
        req_data[0] = 64'h99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_val", {63'd0, rsp_val[0]}, 64'd1);
            chk("hold_data", rsp_data[0], 64'h1234);
            chk("hold_req_rdy", {63'd0, req_rdy[0]}, 64'd0);
        end
        ack(0);
        chk("post_hs_val", {63'd0, rsp_val[0]}, 64'd0);
        chk("post_hs_rdy", {63'd0, req_rdy[0]}, 64'd1);
        send(0, 1'b1, 1'b0, 64'h18, 64'h99);
        chk("busy_rdy", {63'd0, req_rdy[0]}, 64'd0);
        await_rsp(0, rsp, lat);
        chk("pend_lat", 64'(lat), 64'd2);
        chk("pend_rsp", rsp, 64'd0);
        ack(0);
        xact(0, "ld18_pend", 1'b0, 1'b0, 64'h18, 64'd0, 64'h99);

        // Address wrap and ignored byte offset.
        xact(0, "st_wrap", 1'b1, 1'b0, 64'd2056, 64'hAA, 64'd0);
        xact(0, "ld_wrap", 1'b0, 1'b0, 64'h8, 64'd0, 64'hAA);
        xact(0, "ld_offs", 1'b0, 1'b0, 64'hF, 64'd0, 64'hAA);

        // Reset while a store is in flight.
        send(0, 1'b1, 1'b0, 64'h10, 64'h77);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy_val", {63'd0, rsp_val[0]}, 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_fail_cnt", {48'd0, fail_cnt[0]}, 64'd0);
        xact(0, "ld10_dropped", 1'b0, 1'b0, 64'h10, 64'd0, 64'd0);
        xact(0, "ld0_reset", 1'b0, 1'b0, 64'h0, 64'd0, EXP_VAL);

        // Failure counter: count up, then saturate.
        xact(0, "sat_lock", 1'b0, 1'b1, 64'h0, 64'h5, 64'd0);
        xact(0, "sat_f1", 1'b0, 1'b1, 64'h0, 64'h6, 64'd1);
        xact(0, "sat_f2", 1'b0, 1'b1, 64'h0, 64'h6, 64'd1);
        chk("fail_cnt_2", {48'd0, fail_cnt[0]}, 64'd2);
        // Preload the counter near its ceiling.
        force u_dut0.cas_fail_cnt_q = 16'hFFFC;
        @(posedge clk);
        @(negedge clk);
        release u_dut0.cas_fail_cnt_q;
        xact(0, "sat_f3", 1'b0, 1'b1, 64'h0, 64'h6, 64'd1);
        chk("fail_cnt_fffd", {48'd0, fail_cnt[0]}, 64'hFFFD);
        xact(0, "sat_f4", 1'b0, 1'b1, 64'h0, 64'h6, 64'd1);
        chk("fail_cnt_fffe", {48'd0, fail_cnt[0]}, 64'hFFFE);
        xact(0, "sat_f5", 1'b0, 1'b1, 64'h0, 64'h6, 64'd1);
        chk("fail_cnt_ffff", {48'd0, fail_cnt[0]}, 64'hFFFF);
        xact(0, "sat_f6", 1'b0, 1'b1, 64'h0, 64'h6, 64'd1);
        chk("fail_cnt_sat", {48'd0, fail_cnt[0]}, 64'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
